red_pitaya_na_multi_averager: RTL and testbench
===============================================

// Module: red_pitaya_na_multi_averager
// PURPOSE
//  Parametrised N-channel network-analyzer averager: after a start pulse, waits a programmable
//  settling time, then sums NCH signed demodulated quadratures over a programmable sample count.
//  Adds a snapshot output with valid/ack handshake, continuous re-arm, per-channel saturation and overrun flags.
//  Sits after the IQ block quadrature low-pass filters; its bus wrapper maps sums/flags to PS registers.
// PARAMETERS
//  NCH      2   number of input channels (>=1)
//  INBITS   24  signed width of each input sample
//  SUMBITS  62  signed width of each accumulator / snapshot (> INBITS)
//  CNTBITS  32  width of averages / sleep counters
// PORTS
//  clk_i         in   1               clock
//  rst_i         in   1               synchronous reset, active high
//  start_i       in   1               pulse: latch cfg, clear sums, begin series
//  abort_i       in   1               pulse: stop series, return to IDLE
//  cfg_avg_i     in   CNTBITS         samples to sum per series
//  cfg_sleep_i   in   CNTBITS         settling cycles before summing
//  cfg_cont_i    in   1               1 = re-arm automatically after each completion
//  dat_i         in   NCH*INBITS      packed signed samples, channel 0 in LSBs
//  sum_o         out  NCH*SUMBITS     packed snapshot of completed sums
//  valid_o       out  1               snapshot unread; cleared by ack_i
//  ack_i         in   1               consumer has read sum_o
//  done_o        out  1               one-cycle pulse at each completion
//  busy_o        out  1               state is SLEEP or ACCUM
//  remaining_o   out  CNTBITS         samples still to sum in current series
//  sat_o         out  NCH             sticky per-channel saturation, cleared by start_i
//  overrun_o     out  1               sticky: snapshot overwritten while valid_o=1; cleared by start_i
// BEHAVIOUR
//  Reset: state IDLE; all outputs, accumulators, counters and latched cfg = 0.
//  FSM IDLE/SLEEP/ACCUM/HOLD. start_i in any state -> clear accumulators, sat_o, overrun_o;
//   latch cfg_*; next state SLEEP if cfg_sleep_i!=0, else ACCUM. remaining_o<=cfg_avg_i.
//  SLEEP: stays exactly cfg_sleep cycles, then ACCUM.
//  ACCUM: each cycle acc[c] += sign-extended dat_i[c]; remaining_o decrements; after exactly
//   cfg_avg samples completes. cfg_avg==0: completes on first ACCUM cycle with zero sums.
//  Completion (registered): sum_o<=final acc values, valid_o<=1, done_o=1 for 1 cycle;
//   next state HOLD if latched cont=0, else re-arm with latched cfg (clear acc, SLEEP/ACCUM).
//  Latency: start_i at cycle t, sleep S, avg N>0 -> done_o/valid_o high at t+1+S+N; sample
//   presented at cycles t+1+S .. t+S+N are summed.
//  HOLD: idle, sum_o stable; only start_i leaves it (abort_i -> IDLE).
//  sum_o changes only at completion; never shows partial sums.
//  Saturation: if acc+sample exceeds SUMBITS signed range, clamp to max/min and set sat_o[c].
//  Handshake: ack_i clears valid_o next cycle. Completion while valid_o=1 and no ack_i in
//   same cycle -> overwrite sum_o, set overrun_o. Completion and ack_i same cycle -> valid_o=1, no overrun.
//  abort_i: state IDLE, remaining_o=0; sum_o/valid_o unchanged. abort_i and start_i same cycle: abort wins.
//  start_i during ACCUM/SLEEP: restarts cleanly, no done_o for the abandoned series.
//  rst_i mid-series: immediate return to reset state next cycle, no done_o.
// TESTING
//  NCH=2, sleep=3, avg=4, dat={ch1=-2,ch0=5} -> done_o at t+8; sum_o ch0=20, ch1=-8; valid_o=1.
//  avg=0, sleep=0 -> done_o at t+1, sums 0; avg=1 -> sum equals single sample at t+1.
//  SUMBITS=26, INBITS=24, dat ch0=+max, avg=8 -> sum ch0=2^25-1, sat_o[0]=1, sat_o[1]=0.
//  cont=1, avg=2, sleep=0, no ack -> done_o every 2 cycles; overrun_o set after 2nd; ack on completion cycle -> no overrun.
//  abort_i mid-ACCUM (and with start_i same cycle) -> IDLE, no done_o, previous sum_o kept.
//  rst_i asserted during SLEEP -> all outputs 0 next cycle; fresh start_i yields correct sums.

Source files
------------

// File: rtl/red_pitaya_na_multi_averager_if.sv
// Control, data and status bundle between the network-analyzer averager and its bus wrapper.
// Handshake: valid_o rises when a completed series is captured in sum_o; ack_i clears it next cycle.
interface red_pitaya_na_multi_averager_if #(
  parameter int NCH     = 2,
  parameter int INBITS  = 24,
  parameter int SUMBITS = 62,
  parameter int CNTBITS = 32
);
  logic                    start_i;
  logic                    abort_i;
  logic [CNTBITS-1:0]      cfg_avg_i;
  logic [CNTBITS-1:0]      cfg_sleep_i;
  logic                    cfg_cont_i;
  logic [NCH*INBITS-1:0]   dat_i;
  logic                    ack_i;
  logic [NCH*SUMBITS-1:0]  sum_o;
  logic                    valid_o;
  logic                    done_o;
  logic                    busy_o;
  logic [CNTBITS-1:0]      remaining_o;
  logic [NCH-1:0]          sat_o;
  logic                    overrun_o;
  logic [1:0]              state_o;

  modport slave (
    input  start_i, abort_i, cfg_avg_i, cfg_sleep_i, cfg_cont_i, dat_i, ack_i,
    output sum_o, valid_o, done_o, busy_o, remaining_o, sat_o, overrun_o, state_o
  );

  modport master (
    output start_i, abort_i, cfg_avg_i, cfg_sleep_i, cfg_cont_i, dat_i, ack_i,
    input  sum_o, valid_o, done_o, busy_o, remaining_o, sat_o, overrun_o, state_o
  );
endinterface

// File: rtl/red_pitaya_na_multi_averager.sv
// N-channel IQ averager: settle for a programmed time, then sum signed samples with saturation,
// publishing each completed series as a snapshot guarded by a valid/ack handshake.
module red_pitaya_na_multi_averager #(
  parameter int NCH     = 2,
  parameter int INBITS  = 24,
  parameter int SUMBITS = 62,
  parameter int CNTBITS = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  red_pitaya_na_multi_averager_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SLEEP = 2'd1, ST_ACCUM = 2'd2, ST_HOLD = 2'd3} state_t;

  localparam logic [SUMBITS-1:0] SUM_MAX = {1'b0, {(SUMBITS-1){1'b1}}};
  localparam logic [SUMBITS-1:0] SUM_MIN = {1'b1, {(SUMBITS-1){1'b0}}};

  state_t                 r_state, w_state_nxt;
  logic [CNTBITS-1:0]     r_cfg_avg, r_cfg_sleep;
  logic                   r_cfg_cont;
  logic [CNTBITS-1:0]     r_remaining, r_sleep_cnt;
  logic [SUMBITS-1:0]     r_acc [NCH];
  logic [NCH*SUMBITS-1:0] r_sum;
  logic                   r_valid, r_done, r_overrun;
  logic [NCH-1:0]         r_sat;

  logic                   w_start, w_sleep_end, w_acc_end, w_complete, w_from_accum, w_arm;
  logic [CNTBITS-1:0]     w_ld_avg, w_ld_sleep;
  logic                   w_ld_cont;
  logic [SUMBITS:0]       w_ext  [NCH];
  logic [SUMBITS:0]       w_wide [NCH];
  logic [SUMBITS-1:0]     w_acc_add [NCH];
  logic [NCH-1:0]         w_sat_step;

  // abort_i dominates start_i; a start arriving alone always (re)loads the series
  assign w_start     = bus.start_i & ~bus.abort_i;
  assign w_sleep_end = (r_state == ST_SLEEP) && (r_sleep_cnt <= CNTBITS'(1));
  assign w_acc_end   = (r_state == ST_ACCUM) && (r_remaining <= CNTBITS'(1));
  assign w_ld_avg    = w_start ? bus.cfg_avg_i   : r_cfg_avg;
  assign w_ld_sleep  = w_start ? bus.cfg_sleep_i : r_cfg_sleep;
  assign w_ld_cont   = w_start ? bus.cfg_cont_i  : r_cfg_cont;

  // A zero-length series completes on the edge that would otherwise enter ACCUM
  assign w_complete   = ~bus.abort_i &
                        (w_start ? ((bus.cfg_sleep_i == '0) && (bus.cfg_avg_i == '0))
                                 : (w_acc_end | (w_sleep_end && (r_cfg_avg == '0))));
  assign w_from_accum = ~w_start & w_acc_end;
  assign w_arm        = ~bus.abort_i & (w_start | (w_complete & w_ld_cont));

  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort_i)                   w_state_nxt = ST_IDLE;
    else if (w_complete && !w_ld_cont) w_state_nxt = ST_HOLD;
    else if (w_arm)                    w_state_nxt = (w_ld_sleep != '0) ? ST_SLEEP : ST_ACCUM;
    else if (w_sleep_end)              w_state_nxt = ST_ACCUM;
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_ext[c]      = {{(SUMBITS+1-INBITS){bus.dat_i[c*INBITS+INBITS-1]}}, bus.dat_i[c*INBITS +: INBITS]};
      w_wide[c]     = {r_acc[c][SUMBITS-1], r_acc[c]} + w_ext[c];
      w_acc_add[c]  = r_acc[c];
      w_sat_step[c] = 1'b0;
      if (r_remaining != '0) begin
        if (w_wide[c][SUMBITS] != w_wide[c][SUMBITS-1]) begin
          w_acc_add[c]  = w_wide[c][SUMBITS] ? SUM_MIN : SUM_MAX;
          w_sat_step[c] = 1'b1;
        end else begin
          w_acc_add[c]  = w_wide[c][SUMBITS-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cfg_avg   <= '0;
      r_cfg_sleep <= '0;
      r_cfg_cont  <= 1'b0;
      r_remaining <= '0;
      r_sleep_cnt <= '0;
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
      r_sum       <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_sat       <= '0;
    end else begin
      r_done <= w_complete;
      if (w_start) begin
        r_cfg_avg   <= bus.cfg_avg_i;
        r_cfg_sleep <= bus.cfg_sleep_i;
        r_cfg_cont  <= bus.cfg_cont_i;
      end
      if (bus.abort_i) begin
        r_remaining <= '0;
      end else if (w_arm) begin
        r_remaining <= w_ld_avg;
        r_sleep_cnt <= w_ld_sleep;
        for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
      end else if (w_complete) begin
        r_remaining <= '0;
      end else if (r_state == ST_ACCUM) begin
        r_remaining <= r_remaining - CNTBITS'(1);
        for (int c = 0; c < NCH; c++) r_acc[c] <= w_acc_add[c];
      end else if (r_state == ST_SLEEP) begin
        r_sleep_cnt <= r_sleep_cnt - CNTBITS'(1);
      end
      if (w_start)                                    r_sat <= '0;
      else if (!bus.abort_i && r_state == ST_ACCUM)   r_sat <= r_sat | w_sat_step;
      if (w_complete && r_valid && !bus.ack_i)        r_overrun <= 1'b1;
      else if (w_start)                               r_overrun <= 1'b0;
      // The snapshot only ever moves at completion, so a reader never sees partial sums
      if (w_complete) begin
        r_valid <= 1'b1;
        for (int c = 0; c < NCH; c++)
          r_sum[c*SUMBITS +: SUMBITS] <= w_from_accum ? w_acc_add[c] : '0;
      end else if (bus.ack_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.sum_o       = r_sum;
  assign bus.valid_o     = r_valid;
  assign bus.done_o      = r_done;
  assign bus.busy_o      = (r_state == ST_SLEEP) || (r_state == ST_ACCUM);
  assign bus.remaining_o = r_remaining;
  assign bus.sat_o       = r_sat;
  assign bus.overrun_o   = r_overrun;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_red_pitaya_na_multi_averager.sv
// Bench for the N-channel averager: scenario tasks drive series and check timing/flags inline,
// while a done_o monitor compares every snapshot against a queue of model sums.
module tb_red_pitaya_na_multi_averager;
  localparam int NCH = 2, INBITS = 24, SUMBITS = 26, CNTBITS = 32;
  localparam int SW = NCH * SUMBITS;
  localparam longint SMAX = (longint'(1) << (SUMBITS - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (SUMBITS - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] mon_exp;

  red_pitaya_na_multi_averager_if #(.NCH(NCH), .INBITS(INBITS), .SUMBITS(SUMBITS), .CNTBITS(CNTBITS)) bif();

  red_pitaya_na_multi_averager #(.NCH(NCH), .INBITS(INBITS), .SUMBITS(SUMBITS), .CNTBITS(CNTBITS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] pack2(input longint a0, input longint a1);
    logic [SW-1:0] r;
    r[SUMBITS-1:0]  = a0[SUMBITS-1:0];
    r[SW-1:SUMBITS] = a1[SUMBITS-1:0];
    return r;
  endfunction

  // Scoreboard side: every done_o pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && bif.done_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: sum_o=%h, none expected", bif.sum_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bif.sum_o !== mon_exp) begin
          errors++;
          $display("FAIL snapshot_sum: got %h expected %h", bif.sum_o, mon_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic set_dat(input longint d0, input longint d1);
    bif.dat_i = {d1[INBITS-1:0], d0[INBITS-1:0]};
  endtask

  task automatic start_series(input int sleep, input int avg, input bit cont);
    bif.cfg_sleep_i = CNTBITS'(sleep);
    bif.cfg_avg_i   = CNTBITS'(avg);
    bif.cfg_cont_i  = cont;
    bif.start_i     = 1'b1;
    @(negedge clk);
    bif.start_i     = 1'b0;
  endtask

  task automatic do_ack();
    bif.ack_i = 1'b1;
    @(negedge clk);
    bif.ack_i = 1'b0;
  endtask

  task automatic wait_done(input int exp_k, input string name);
    int k = 0;
    while (bif.done_o !== 1'b1 && k < exp_k + 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bif.done_o !== 1'b1 || k != exp_k) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles (done_o=%b), expected %0d", name, k, bif.done_o, exp_k);
    end
  endtask

  task automatic test_reset();
    bif.start_i = 0; bif.abort_i = 0; bif.cfg_avg_i = '0; bif.cfg_sleep_i = '0;
    bif.cfg_cont_i = 0; bif.dat_i = '0; bif.ack_i = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bif.sum_o !== '0)         begin errors++; $display("FAIL reset_sum: got %h expected 0", bif.sum_o); end
    checks++; if (bif.valid_o !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", bif.valid_o); end
    checks++; if (bif.done_o !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", bif.done_o); end
    checks++; if (bif.busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", bif.busy_o); end
    checks++; if (bif.remaining_o !== '0)   begin errors++; $display("FAIL reset_remaining: got %0d expected 0", bif.remaining_o); end
    checks++; if (bif.sat_o !== 2'b00)      begin errors++; $display("FAIL reset_sat: got %b expected 00", bif.sat_o); end
    checks++; if (bif.overrun_o !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b expected 0", bif.overrun_o); end
    checks++; if (bif.state_o !== 2'd0)     begin errors++; $display("FAIL reset_state: got %0d expected 0", bif.state_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_dat(5, -2);
    exp_q.push_back(pack2(20, -8));
    start_series(3, 4, 0);
    checks++; if (bif.busy_o !== 1'b1)       begin errors++; $display("FAIL basic_busy: got %b expected 1", bif.busy_o); end
    checks++; if (bif.remaining_o !== 32'd4) begin errors++; $display("FAIL basic_remaining: got %0d expected 4", bif.remaining_o); end
    checks++; if (bif.state_o !== 2'd1)      begin errors++; $display("FAIL basic_state_sleep: got %0d expected 1", bif.state_o); end
    wait_done(7, "basic");
    checks++; if (bif.valid_o !== 1'b1)      begin errors++; $display("FAIL basic_valid: got %b expected 1", bif.valid_o); end
    @(negedge clk);
    checks++; if (bif.done_o !== 1'b0)       begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bif.done_o); end
    checks++; if (bif.state_o !== 2'd3)      begin errors++; $display("FAIL basic_state_hold: got %0d expected 3", bif.state_o); end
    checks++; if (bif.sum_o !== pack2(20, -8)) begin errors++; $display("FAIL basic_hold_sum: got %h expected %h", bif.sum_o, pack2(20, -8)); end
    do_ack();
    checks++; if (bif.valid_o !== 1'b0)      begin errors++; $display("FAIL basic_ack_valid: got %b expected 0", bif.valid_o); end
  endtask

  task automatic test_zero_one();
    set_dat(11, -7);
    exp_q.push_back(pack2(0, 0));
    start_series(0, 0, 0);
    wait_done(0, "avg0");
    do_ack();
    checks++; if (bif.state_o !== 2'd3) begin errors++; $display("FAIL avg0_state: got %0d expected 3", bif.state_o); end
    exp_q.push_back(pack2(11, -7));
    start_series(0, 1, 0);
    wait_done(1, "avg1");
    checks++; if (bif.overrun_o !== 1'b0) begin errors++; $display("FAIL avg1_overrun: got %b expected 0", bif.overrun_o); end
    do_ack();
  endtask

  task automatic test_saturation();
    set_dat(8388607, 3);
    exp_q.push_back(pack2(SMAX, 24));
    start_series(0, 8, 0);
    wait_done(8, "sat");
    checks++; if (bif.sat_o !== 2'b01) begin errors++; $display("FAIL sat_flags: got %b expected 01", bif.sat_o); end
    do_ack();
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int s, n;
      longint d0[16], d1[16];
      longint a0, a1;
      logic [1:0] es;
      s = $urandom_range(0, 4);
      n = $urandom_range(1, 6);
      a0 = 0; a1 = 0; es = 2'b00;
      for (int k = 0; k < 16; k++) begin
        d0[k] = longint'($urandom_range(0, 16777215)) - 8388608;
        d1[k] = longint'($urandom_range(0, 16777215)) - 8388608;
      end
      for (int k = s; k < s + n; k++) begin
        a0 += d0[k]; a1 += d1[k];
        if (a0 > SMAX) begin a0 = SMAX; es[0] = 1'b1; end
        if (a0 < SMIN) begin a0 = SMIN; es[0] = 1'b1; end
        if (a1 > SMAX) begin a1 = SMAX; es[1] = 1'b1; end
        if (a1 < SMIN) begin a1 = SMIN; es[1] = 1'b1; end
      end
      exp_q.push_back(pack2(a0, a1));
      set_dat(d0[15], d1[15]);
      start_series(s, n, 0);
      checks++; if (bif.sat_o !== 2'b00) begin errors++; $display("FAIL rand_sat_cleared: got %b expected 00", bif.sat_o); end
      for (int k = 0; k <= s + n; k++) begin
        checks++;
        if (bif.done_o !== (k == s + n)) begin
          errors++;
          $display("FAIL rand_done_timing: k=%0d done_o=%b expected %b (s=%0d n=%0d)", k, bif.done_o, k == s + n, s, n);
        end
        set_dat(d0[k], d1[k]);
        if (k < s + n) @(negedge clk);
      end
      checks++; if (bif.sat_o !== es) begin errors++; $display("FAIL rand_sat: got %b expected %b", bif.sat_o, es); end
      do_ack();
    end
  endtask

  task automatic test_cont_overrun();
    set_dat(1, -1);
    repeat (2) exp_q.push_back(pack2(2, -2));
    start_series(0, 2, 1);
    for (int k = 0; k <= 4; k++) begin
      checks++; if (bif.done_o !== (k == 2 || k == 4)) begin errors++; $display("FAIL cont_done: k=%0d got %b", k, bif.done_o); end
      if (k == 2) begin checks++; if (bif.overrun_o !== 1'b0) begin errors++; $display("FAIL cont_overrun_first: got %b expected 0", bif.overrun_o); end end
      if (k == 4) begin checks++; if (bif.overrun_o !== 1'b1) begin errors++; $display("FAIL cont_overrun_second: got %b expected 1", bif.overrun_o); end end
      if (k < 4) @(negedge clk);
    end
    repeat (3) exp_q.push_back(pack2(2, -2));
    start_series(0, 2, 1);
    for (int k = 0; k <= 6; k++) begin
      checks++; if (bif.done_o !== (k == 2 || k == 4 || k == 6)) begin errors++; $display("FAIL ackcont_done: k=%0d got %b", k, bif.done_o); end
      checks++; if (bif.overrun_o !== 1'b0) begin errors++; $display("FAIL ackcont_overrun: k=%0d got %b expected 0", k, bif.overrun_o); end
      if (k >= 2) begin checks++; if (bif.valid_o !== 1'b1) begin errors++; $display("FAIL ackcont_valid: k=%0d got %b expected 1", k, bif.valid_o); end end
      bif.ack_i = (k % 2 == 1);
      if (k < 6) @(negedge clk);
    end
    bif.abort_i = 1'b1;
    @(negedge clk);
    bif.abort_i = 1'b0;
    checks++; if (bif.state_o !== 2'd0)    begin errors++; $display("FAIL cont_abort_state: got %0d expected 0", bif.state_o); end
    checks++; if (bif.remaining_o !== '0)  begin errors++; $display("FAIL cont_abort_remaining: got %0d expected 0", bif.remaining_o); end
  endtask

  task automatic test_abort();
    set_dat(9, 9);
    start_series(1, 5, 0);
    repeat (3) @(negedge clk);
    bif.abort_i = 1'b1;
    @(negedge clk);
    bif.abort_i = 1'b0;
    checks++; if (bif.state_o !== 2'd0)       begin errors++; $display("FAIL abort_state: got %0d expected 0", bif.state_o); end
    checks++; if (bif.remaining_o !== '0)     begin errors++; $display("FAIL abort_remaining: got %0d expected 0", bif.remaining_o); end
    checks++; if (bif.busy_o !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b expected 0", bif.busy_o); end
    checks++; if (bif.valid_o !== 1'b1)      begin errors++; $display("FAIL abort_valid_kept: got %b expected 1", bif.valid_o); end
    repeat (8) @(negedge clk);
    checks++; if (bif.sum_o !== pack2(2, -2)) begin errors++; $display("FAIL abort_sum_kept: got %h expected %h", bif.sum_o, pack2(2, -2)); end
    start_series(0, 3, 0);
    bif.cfg_avg_i = 32'd2;
    bif.start_i = 1'b1;
    bif.abort_i = 1'b1;
    @(negedge clk);
    bif.start_i = 1'b0;
    bif.abort_i = 1'b0;
    checks++; if (bif.state_o !== 2'd0)       begin errors++; $display("FAIL startabort_state: got %0d expected 0", bif.state_o); end
    checks++; if (bif.remaining_o !== '0)     begin errors++; $display("FAIL startabort_remaining: got %0d expected 0", bif.remaining_o); end
    repeat (5) @(negedge clk);
    checks++; if (bif.sum_o !== pack2(2, -2)) begin errors++; $display("FAIL startabort_sum_kept: got %h expected %h", bif.sum_o, pack2(2, -2)); end
  endtask

  task automatic test_reset_mid();
    start_series(5, 2, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bif.sum_o !== '0)       begin errors++; $display("FAIL midrst_sum: got %h expected 0", bif.sum_o); end
    checks++; if (bif.valid_o !== 1'b0)   begin errors++; $display("FAIL midrst_valid: got %b expected 0", bif.valid_o); end
    checks++; if (bif.busy_o !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b expected 0", bif.busy_o); end
    checks++; if (bif.remaining_o !== '0) begin errors++; $display("FAIL midrst_remaining: got %0d expected 0", bif.remaining_o); end
    checks++; if (bif.state_o !== 2'd0)   begin errors++; $display("FAIL midrst_state: got %0d expected 0", bif.state_o); end
    rst = 1'b0;
    set_dat(7, -4);
    exp_q.push_back(pack2(21, -12));
    start_series(0, 3, 0);
    wait_done(3, "after_reset");
    do_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_one();
    test_saturation();
    test_random();
    test_cont_overrun();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d snapshots never produced, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
